music_sequencer: RTL
====================

Name: music_sequencer

Overview:
- Sequences a song from a note memory into the music-box frequency divider.
- Steps through note words in order; each word holds a pitch divisor and a duration.
- Drives the divider's divisor input and its mute/reset input.
- Inserts an articulation gap between notes, handles rests, the end-of-song marker and optional looping.

Parameters:
ADDR_W, 8, note memory address width (song length up to 2^ADDR_W words)
DUR_W, 8, duration field width, in beat ticks
TEMPO_DIV, 2500000, fin cycles per beat tick (must be >= 1)
GAP_CYCLES, 1000, muted fin cycles between notes (0 = no gap state)
LOOP, 0, 1 = restart at address 0 after end marker; 0 = stop

Ports:
fin  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin playback at address 0; ignored unless idle
stop  in  1  abort playback; wins over start when both are asserted
pause  in  1  level; freezes playback and mutes output while high
rom_addr  out  ADDR_W  note memory address
rom_data  in  32+DUR_W  {dur[DUR_W-1:0], div[31:0]}; synchronous memory, 1-cycle read latency
Divn  out  32  divisor to the frequency divider
mute  out  1  to the divider's reset input; 1 = silence
busy  out  1  high in every state except IDLE
song_done  out  1  one-cycle pulse when the end marker is reached and LOOP=0
note_idx  out  ADDR_W  address of the note currently latched

Behaviour:
- Reset (async, immediate):
  - State = IDLE; rom_addr = 0, note_idx = 0, Divn = 0.
  - mute = 1, busy = 0, song_done = 0.
  - Internal tick and duration counters = 0.
- States: IDLE, FETCH, LATCH, PLAY, GAP, DONE.
- mute = 1 in every state except PLAY with pause low. Divn holds its last latched value outside LATCH.
- IDLE:
  - start=1 and stop=0 → rom_addr <= 0, go to FETCH.
- FETCH: one cycle with rom_addr stable, then go to LATCH.
- LATCH: sample rom_data and branch:
  - dur == 0 (end marker):
    - LOOP=1 → rom_addr <= 0, go to FETCH.
    - LOOP=0 → go to DONE.
  - Otherwise:
    - Divn <= div, note_idx <= rom_addr, duration counter <= dur, tick counter <= 0, go to PLAY.
    - div == 0 is a rest: Divn <= 0 and mute stays 1 for the whole PLAY.
- Latency: start sampled at edge k → Divn valid and mute low after edge k+2.
- PLAY:
  - Tick counter runs 0..TEMPO_DIV-1. At TEMPO_DIV-1 it wraps to 0 and the duration counter decrements.
  - When that terminal tick occurs with the duration counter at 1 → go to GAP, or straight to the next fetch if GAP_CYCLES = 0.
  - PLAY therefore lasts exactly dur*TEMPO_DIV unpaused cycles.
  - pause=1: both counters frozen, mute=1, Divn held. Resumes the cycle after pause falls with no lost or extra cycles.
- GAP:
  - Lasts GAP_CYCLES cycles (pause freezes it).
  - Then rom_addr <= rom_addr+1 and go to FETCH.
  - Address wraps modulo 2^ADDR_W: a song with no end marker loops by wrap-around.
- DONE: song_done = 1 for exactly one cycle, then go to IDLE.
- stop=1 in any state:
  - Next state is IDLE; mute=1 after that edge. Divn and note_idx hold their values.
  - Counters clear; song_done is not pulsed.
- start while busy: ignored.
- pause in IDLE or DONE: no effect.
- Duration counter is DUR_W bits. Tick counter width is ceil(log2(TEMPO_DIV)), minimum 1; TEMPO_DIV=1 decrements every cycle.
- Outputs are registered; none depends combinationally on an input.

Test Plan:
All tests use TEMPO_DIV=4, GAP_CYCLES=2, LOOP=0. ROM contents: [0]={2,100}, [1]={1,0}, [2]={3,50}, [3]={0,x}.
1. Pulse start at edge 0:
   - Divn=100 and mute=0 after edge 2, held 8 cycles, then mute=1 for 2 gap cycles.
   - Rest at addr 1: mute stays 1 for 4 cycles with Divn=0.
   - Divn=50 unmuted for 12 cycles.
   - song_done pulses once; busy falls the following cycle.
2. Pause held 5 cycles mid-note at addr 0:
   - mute=1 and Divn=100 throughout the pause.
   - Total unmuted time for that note is still 8 cycles.
3. Assert stop during PLAY of addr 2:
   - IDLE next cycle, mute=1, no song_done.
   - A subsequent start replays from addr 0.
4. LOOP=1:
   - After addr 2 the end marker sends rom_addr to 0; Divn=100 reappears 2 cycles after the marker is latched.
   - song_done never pulses.
5. Assert reset asynchronously mid-GAP (between clock edges):
   - Outputs take reset values immediately.
   - start after reset is released behaves exactly as in test 1.
6. start and stop asserted in the same cycle from IDLE → remains IDLE, busy=0. start pulsed while busy → no restart, note order unchanged.

Source files
------------

// File: rtl/music_sequencer_if.sv
// Control and note-memory bus between a music_sequencer and its host/ROM.
// The master side drives playback controls and ROM data; the slave side is the sequencer.
interface music_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DUR_W  = 8
);
    logic                  start;
    logic                  stop;
    logic                  pause;
    logic [ADDR_W-1:0]     rom_addr;
    logic [32+DUR_W-1:0]   rom_data;
    logic [31:0]           Divn;
    logic                  mute;
    logic                  busy;
    logic                  song_done;
    logic [ADDR_W-1:0]     note_idx;

    modport master (
        output start, stop, pause, rom_data,
        input  rom_addr, Divn, mute, busy, song_done, note_idx
    );

    modport slave (
        input  start, stop, pause, rom_data,
        output rom_addr, Divn, mute, busy, song_done, note_idx
    );
endinterface

// File: rtl/music_sequencer.sv
// Steps through {dur, div} note words and drives a music-box divider's divisor and mute,
// with an articulation gap between notes, rests, an end marker and optional looping.
module music_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int DUR_W      = 8,
    parameter int TEMPO_DIV  = 2500000,
    parameter int GAP_CYCLES = 1000,
    parameter int LOOP       = 0
) (
    input  logic               fin,
    input  logic               reset,
    music_sequencer_if.slave   bus
);
    localparam int TICK_W = (TEMPO_DIV > 1) ? $clog2(TEMPO_DIV) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TEMPO_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, PLAY, GAP, DONE} state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_cnt;
    logic [DUR_W-1:0]    dur_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic [ADDR_W-1:0]   note_idx_q;
    logic [31:0]         divn_q;
    logic                mute_q;
    logic                busy_q;
    logic                song_done_q;

    logic [DUR_W-1:0]    rom_dur;
    logic [31:0]         rom_div;
    logic                tick_end;
    logic                note_end;
    logic                gap_end;
    logic                play_silent;

    assign rom_dur  = bus.rom_data[32 +: DUR_W];
    assign rom_div  = bus.rom_data[31:0];
    assign tick_end = (tick_cnt == TICK_LAST);
    assign note_end = tick_end && (dur_cnt == DUR_W'(1));
    assign gap_end  = (gap_cnt == GAP_LAST);
    // A rest keeps the output muted; in LATCH the new word decides, in PLAY the latched one.
    assign play_silent = (state_q == LATCH) ? (rom_div == 32'd0) : (divn_q == 32'd0);

    always_ff @(posedge fin or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (bus.start) state_d = FETCH;
                FETCH: state_d = LATCH;
                LATCH: begin
                    if (rom_dur == '0) state_d = (LOOP != 0) ? FETCH : DONE;
                    else               state_d = PLAY;
                end
                PLAY:  if (!bus.pause && note_end) state_d = (GAP_CYCLES == 0) ? FETCH : GAP;
                GAP:   if (!bus.pause && gap_end) state_d = FETCH;
                DONE:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge fin or posedge reset) begin
        if (reset) begin
            tick_cnt    <= '0;
            dur_cnt     <= '0;
            gap_cnt     <= '0;
            rom_addr_q  <= '0;
            note_idx_q  <= '0;
            divn_q      <= '0;
            mute_q      <= 1'b1;
            busy_q      <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            busy_q      <= (state_d != IDLE);
            song_done_q <= (state_d == DONE);
            mute_q      <= !((state_d == PLAY) && !bus.pause && !play_silent);
            if (bus.stop) begin
                tick_cnt <= '0;
                dur_cnt  <= '0;
                gap_cnt  <= '0;
            end else begin
                case (state_q)
                    IDLE: if (bus.start) rom_addr_q <= '0;
                    LATCH: begin
                        if (rom_dur == '0) begin
                            if (LOOP != 0) rom_addr_q <= '0;
                        end else begin
                            divn_q     <= rom_div;
                            note_idx_q <= rom_addr_q;
                            dur_cnt    <= rom_dur;
                            tick_cnt   <= '0;
                        end
                    end
                    PLAY: if (!bus.pause) begin
                        if (tick_end) begin
                            tick_cnt <= '0;
                            dur_cnt  <= dur_cnt - 1'b1;
                            gap_cnt  <= '0;
                            if (note_end && (GAP_CYCLES == 0)) rom_addr_q <= rom_addr_q + 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    GAP: if (!bus.pause) begin
                        if (gap_end) begin
                            gap_cnt    <= '0;
                            rom_addr_q <= rom_addr_q + 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.note_idx  = note_idx_q;
    assign bus.Divn      = divn_q;
    assign bus.mute      = mute_q;
    assign bus.busy      = busy_q;
    assign bus.song_done = song_done_q;
endmodule
